// File: rtl/ita_seg14_pkg.sv
// Shared constants for the 14-segment display bus: geometry, glyph patterns
// and the 6-bit character codes they decode to.
package ita_seg14_pkg;

  localparam int NDIG   = 12;
  localparam int SEGW   = 14;
  localparam int CODEW  = 6;
  localparam int IDXW   = 4;
  localparam int NGLYPH = 38;

  typedef logic [SEGW-1:0]  seg_t;
  typedef logic [CODEW-1:0] code_t;

  typedef enum logic {ST_HUNT, ST_CAPTURE} state_e;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  // Bit 13 is segment a, then b c d e f g1 g2, then the six inner strokes.
  localparam seg_t SEG_SPACE  = 14'h0000;
  localparam seg_t SEG_A      = 14'h3BC0;
  localparam seg_t SEG_B      = 14'h3C52;
  localparam seg_t SEG_C      = 14'h2700;
  localparam seg_t SEG_D      = 14'h3C12;
  localparam seg_t SEG_E      = 14'h2780;
  localparam seg_t SEG_F      = 14'h2380;
  localparam seg_t SEG_G      = 14'h2F40;
  localparam seg_t SEG_H      = 14'h1BC0;
  localparam seg_t SEG_I      = 14'h2412;
  localparam seg_t SEG_J      = 14'h1E00;
  localparam seg_t SEG_K      = 14'h038C;
  localparam seg_t SEG_L      = 14'h0700;
  localparam seg_t SEG_M      = 14'h1B28;
  localparam seg_t SEG_N      = 14'h1B24;
  localparam seg_t SEG_O      = 14'h3F00;
  localparam seg_t SEG_P      = 14'h33C0;
  localparam seg_t SEG_Q      = 14'h3F04;
  localparam seg_t SEG_R      = 14'h33C4;
  localparam seg_t SEG_S      = 14'h2DC0;
  localparam seg_t SEG_T      = 14'h2012;
  localparam seg_t SEG_U      = 14'h1F00;
  localparam seg_t SEG_V      = 14'h0309;
  localparam seg_t SEG_W      = 14'h1B05;
  localparam seg_t SEG_X      = 14'h002D;
  localparam seg_t SEG_Y      = 14'h002A;
  localparam seg_t SEG_Z      = 14'h2409;
  localparam seg_t SEG_NTILDE = 14'h3B24;
  localparam seg_t SEG_D0     = 14'h3F09;
  localparam seg_t SEG_D1     = 14'h1808;
  localparam seg_t SEG_D2     = 14'h36C0;
  localparam seg_t SEG_D3     = 14'h3C40;
  localparam seg_t SEG_D4     = 14'h19C0;
  localparam seg_t SEG_D5     = 14'h2DC0;
  localparam seg_t SEG_D6     = 14'h2FC0;
  localparam seg_t SEG_D7     = 14'h3800;
  localparam seg_t SEG_D8     = 14'h3FC0;
  localparam seg_t SEG_D9     = 14'h3DC0;

  localparam code_t CODE_SPACE  = 6'd0;
  localparam code_t CODE_A      = 6'd1;
  localparam code_t CODE_NTILDE = 6'd27;
  localparam code_t CODE_D0     = 6'd28;
  localparam code_t CODE_UNK    = 6'd63;

  // Table position is the character code; digit 5 shares the S pattern and
  // loses to it because the lower code wins.
  localparam seg_t GLYPH_TAB [NGLYPH] = '{
    SEG_SPACE,
    SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_H, SEG_I,
    SEG_J, SEG_K, SEG_L, SEG_M, SEG_N, SEG_O, SEG_P, SEG_Q, SEG_R,
    SEG_S, SEG_T, SEG_U, SEG_V, SEG_W, SEG_X, SEG_Y, SEG_Z,
    SEG_NTILDE,
    SEG_D0, SEG_D1, SEG_D2, SEG_D3, SEG_D4,
    SEG_D5, SEG_D6, SEG_D7, SEG_D8, SEG_D9
  };

endpackage

// File: rtl/seg14_glyph_decode.sv
// Combinational 14-segment pattern to character code lookup; anything that
// is not an exact glyph match decodes as the unknown code.
module seg14_glyph_decode
  import ita_seg14_pkg::*;
(
  input  logic [SEGW-1:0]  segm_i,
  output logic [CODEW-1:0] code_o
);

  // Scan downwards so the lowest matching code is the one that sticks.
  always_comb begin
    code_o = CODE_UNK;
    for (int i = NGLYPH - 1; i >= 0; i--) begin
      if (segm_i == GLYPH_TAB[i]) code_o = CODEW'(i);
    end
  end

endmodule

// File: rtl/ita_scan_decoder.sv
// Receive side of the multiplexed 14-segment display bus: rebuilds each
// complete 0..11 digit scan into a double-buffered 12-character frame.
module ita_scan_decoder
  import ita_seg14_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NDIG-1:0]  sel,
  input  logic [SEGW-1:0]  segm,
  input  logic [3:0]       rd_addr,
  output logic [CODEW-1:0] rd_char,
  output logic             frame_valid,
  output logic             frame_unk,
  output logic [7:0]       frame_cnt,
  output logic             seq_err,
  output logic             onehot_err,
  output logic             locked
);

  localparam logic [NDIG-1:0] SEL_ONE = NDIG'(1);

  logic [NDIG-1:0] sel_q;
  logic [SEGW-1:0] segm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      segm_q <= '0;
    end else begin
      sel_q  <= sel;
      segm_q <= segm;
    end
  end

  logic [IDXW-1:0] idx;
  logic            selZero;
  logic            selMulti;
  logic            digitOk;
  code_t           glyphCode;

  // idx is only meaningful when exactly one select bit is set.
  always_comb begin
    idx = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (sel_q[k]) idx = IDXW'(k);
    end
    selZero  = (sel_q == '0);
    selMulti = |(sel_q & (sel_q - SEL_ONE));
    digitOk  = !selZero && !selMulti;
  end

  seg14_glyph_decode uDecode (
    .segm_i (segm_q),
    .code_o (glyphCode)
  );

  state_e          state_q, state_d;
  logic [IDXW-1:0] expect_q, expect_d;
  logic            shadowWr, frameDone, seqErr_d, onehotErr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      expect_q <= '0;
    end else begin
      state_q  <= state_d;
      expect_q <= expect_d;
    end
  end

  // The last digit rewinds expect to 0 without leaving CAPTURE so the next
  // scan can follow with no gap.
  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    case (state_q)
      ST_HUNT: begin
        if (digitOk && idx == '0) begin
          state_d  = ST_CAPTURE;
          expect_d = IDXW'(1);
        end
      end
      ST_CAPTURE: begin
        if (!digitOk || idx != expect_q) begin
          state_d  = ST_HUNT;
          expect_d = '0;
        end else if (idx == LAST_IDX) begin
          expect_d = '0;
        end else begin
          expect_d = expect_q + IDXW'(1);
        end
      end
      default: begin
        state_d  = ST_HUNT;
        expect_d = '0;
      end
    endcase
  end

  always_comb begin
    shadowWr    = 1'b0;
    frameDone   = 1'b0;
    seqErr_d    = 1'b0;
    onehotErr_d = 1'b0;
    locked      = (state_q == ST_CAPTURE);
    case (state_q)
      ST_HUNT: begin
        onehotErr_d = selMulti;
        shadowWr    = digitOk && idx == '0;
      end
      ST_CAPTURE: begin
        onehotErr_d = selMulti;
        seqErr_d    = !selMulti && (selZero || idx != expect_q);
        shadowWr    = digitOk && idx == expect_q;
        frameDone   = digitOk && idx == expect_q && idx == LAST_IDX;
      end
      default: ;
    endcase
  end

  code_t      shadow_q [NDIG];
  code_t      disp_q   [NDIG];
  logic       frameValid_q, frameUnk_q, seqErr_q, onehotErr_q;
  logic [7:0] frameCnt_q;
  logic       frameUnk_d;

  // The final digit bypasses the shadow so it lands in the same commit.
  always_comb begin
    frameUnk_d = (glyphCode == CODE_UNK);
    for (int k = 0; k < NDIG - 1; k++) begin
      if (shadow_q[k] == CODE_UNK) frameUnk_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NDIG; k++) begin
        shadow_q[k] <= CODE_SPACE;
        disp_q[k]   <= CODE_SPACE;
      end
      frameValid_q <= 1'b0;
      frameUnk_q   <= 1'b0;
      seqErr_q     <= 1'b0;
      onehotErr_q  <= 1'b0;
      frameCnt_q   <= '0;
    end else begin
      frameValid_q <= frameDone;
      seqErr_q     <= seqErr_d;
      onehotErr_q  <= onehotErr_d;
      if (shadowWr) shadow_q[idx] <= glyphCode;
      if (frameDone) begin
        for (int k = 0; k < NDIG - 1; k++) disp_q[k] <= shadow_q[k];
        disp_q[NDIG-1] <= glyphCode;
        frameUnk_q     <= frameUnk_d;
        frameCnt_q     <= frameCnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    rd_char = CODE_SPACE;
    if (rd_addr < IDXW'(NDIG)) rd_char = disp_q[rd_addr];
  end

  assign frame_valid = frameValid_q;
  assign frame_unk   = frameUnk_q;
  assign frame_cnt   = frameCnt_q;
  assign seq_err     = seqErr_q;
  assign onehot_err  = onehotErr_q;

endmodule

// File: tb/tb_ita_scan_decoder.sv
// Bench for ita_scan_decoder: frames are queued as expectations when driven
// and checked by a monitor whenever the decoder reports a completed frame.
module tb_ita_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sel;
  logic [13:0] segm;
  logic [3:0]  rd_addr;
  logic [5:0]  rd_char;
  logic        frame_valid, frame_unk, seq_err, onehot_err, locked;
  logic [7:0]  frame_cnt;

  ita_scan_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .segm        (segm),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .frame_valid (frame_valid),
    .frame_unk   (frame_unk),
    .frame_cnt   (frame_cnt),
    .seq_err     (seq_err),
    .onehot_err  (onehot_err),
    .locked      (locked)
  );

  always #20 clk = ~clk;

  localparam bit [13:0] GLYPHS [38] = '{
    14'h0000,
    14'h3BC0, 14'h3C52, 14'h2700, 14'h3C12, 14'h2780, 14'h2F40 ^ 14'h0CC0, 14'h2F40,
    14'h1BC0, 14'h2412, 14'h1E00, 14'h038C, 14'h0700, 14'h1B28, 14'h1B24,
    14'h3F00, 14'h33C0, 14'h3F04, 14'h33C4, 14'h2DC0, 14'h2012, 14'h1F00,
    14'h0309, 14'h1B05, 14'h002D, 14'h002A, 14'h2409,
    14'h3B24,
    14'h3F09, 14'h1808, 14'h36C0, 14'h3C40, 14'h19C0,
    14'h2DC0, 14'h2FC0, 14'h3800, 14'h3FC0, 14'h3DC0
  };

  typedef struct packed {
    logic [11:0][5:0] codes;
    logic             unk;
    logic [7:0]       cnt;
  } frame_t;

  frame_t     expQ [$];
  frame_t     lastExp;
  int         fvCycles [$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cycleNo = 0;
  int         seqCount = 0, ohCount = 0, fvCount = 0;
  int         lockDrops = 0;
  bit         trackLock = 1'b0;
  logic [7:0] modelCnt = 8'd0;
  logic       sFv, sUnk, sSeq, sOh, sLocked;
  logic [7:0] sCnt;

  always @(posedge clk) cycleNo++;

  // Scoreboard: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    frame_t cur;
    logic [5:0] ex;
    if (seq_err === 1'b1) seqCount++;
    if (onehot_err === 1'b1) ohCount++;
    if (frame_valid === 1'b1) begin
      fvCount++;
      fvCycles.push_back(cycleNo);
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_frame: frame_valid=1 but expected no frame (cnt=%0d)", frame_cnt);
      end else begin
        cur = expQ.pop_front();
        lastExp = cur;
        vectors++;
        if (frame_cnt !== cur.cnt) begin
          miscompares++;
          $display("[TB] FAIL frame_cnt: got %0d expected %0d", frame_cnt, cur.cnt);
        end
        vectors++;
        if (frame_unk !== cur.unk) begin
          miscompares++;
          $display("[TB] FAIL frame_unk: got %0b expected %0b", frame_unk, cur.unk);
        end
        for (int a = 0; a < 16; a++) begin
          rd_addr = 4'(a);
          #1;
          ex = 6'd0;
          if (a < 12) ex = cur.codes[a];
          vectors++;
          if (rd_char !== ex) begin
            miscompares++;
            $display("[TB] FAIL rd_char[%0d]: got %0d expected %0d (frame %0d)", a, rd_char, ex, cur.cnt);
          end
        end
      end
    end
  end

  // One bus cycle: sample outputs left by the previous edge, then drive.
  task automatic applyStimulus(input logic [11:0] selv, input logic [13:0] segv);
    @(negedge clk);
    sFv     = frame_valid;
    sUnk    = frame_unk;
    sCnt    = frame_cnt;
    sSeq    = seq_err;
    sOh     = onehot_err;
    sLocked = locked;
    if (trackLock && sLocked !== 1'b1) lockDrops++;
    sel  = selv;
    segm = segv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(12'h000, 14'h0000);
  endtask

  // Code 63 stands for an unrecognised pattern; code 33 (digit 5) reads back as S.
  task automatic sendFrame(input int codes [12]);
    frame_t e;
    e.unk = 1'b0;
    for (int k = 0; k < 12; k++) begin
      e.codes[k] = (codes[k] == 33) ? 6'd19 : 6'(codes[k]);
      if (codes[k] == 63) e.unk = 1'b1;
    end
    modelCnt = modelCnt + 8'd1;
    e.cnt = modelCnt;
    expQ.push_back(e);
    for (int k = 0; k < 12; k++)
      applyStimulus(12'b1 << k, (codes[k] == 63) ? 14'h3FFF : GLYPHS[codes[k]]);
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = '0; segm = '0; rd_addr = '0;
    #5;
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fv: got %0b expected 0", frame_valid); end
    vectors++; if (frame_unk !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_unk: got %0b expected 0", frame_unk); end
    vectors++; if (frame_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_cnt: got %0d expected 0", frame_cnt); end
    vectors++; if (seq_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_seq: got %0b expected 0", seq_err); end
    vectors++; if (onehot_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_oh: got %0b expected 0", onehot_err); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_locked: got %0b expected 0", locked); end
    vectors++; if (rd_char !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_rd: got %0d expected 0", rd_char); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelCnt = 8'd0;
  endtask

  task automatic test_nominal();
    int nom [12] = '{5, 13, 13, 1, 0, 10, 1, 18, 0, 7, 1, 18};
    sendFrame(nom);
    applyStimulus(12'h000, 14'h0000);
    vectors++; if (sFv !== 1'b0) begin miscompares++; $display("[TB] FAIL nominal_fv_early: got %0b expected 0", sFv); end
    applyStimulus(12'h000, 14'h0000);
    vectors++; if (sFv !== 1'b1) begin miscompares++; $display("[TB] FAIL nominal_fv: got %0b expected 1", sFv); end
    vectors++; if (sCnt !== 8'd1) begin miscompares++; $display("[TB] FAIL nominal_cnt: got %0d expected 1", sCnt); end
    vectors++; if (sLocked !== 1'b1) begin miscompares++; $display("[TB] FAIL nominal_locked: got %0b expected 1", sLocked); end
    applyStimulus(12'h000, 14'h0000);
    vectors++; if (sFv !== 1'b0) begin miscompares++; $display("[TB] FAIL nominal_fv_once: got %0b expected 0", sFv); end
    vectors++; if (sSeq !== 1'b1) begin miscompares++; $display("[TB] FAIL nominal_idle_seq: got %0b expected 1", sSeq); end
    vectors++; if (sLocked !== 1'b0) begin miscompares++; $display("[TB] FAIL nominal_unlock: got %0b expected 0", sLocked); end
    idle(3);
  endtask

  task automatic test_seq_error();
    int s0, f0;
    int fb [12] = '{28, 29, 30, 31, 32, 33, 34, 35, 36, 37, 27, 26};
    #2; s0 = seqCount; f0 = fvCount;
    for (int k = 0; k < 4; k++) applyStimulus(12'b1 << k, GLYPHS[28 + k]);
    applyStimulus(12'b1 << 5, GLYPHS[19]);
    applyStimulus(12'h000, 14'h0000);
    vectors++; if (sLocked !== 1'b1) begin miscompares++; $display("[TB] FAIL seq_prelock: got %0b expected 1", sLocked); end
    applyStimulus(12'h000, 14'h0000);
    vectors++; if (sSeq !== 1'b1) begin miscompares++; $display("[TB] FAIL seq_pulse: got %0b expected 1", sSeq); end
    vectors++; if (sLocked !== 1'b0) begin miscompares++; $display("[TB] FAIL seq_unlock: got %0b expected 0", sLocked); end
    applyStimulus(12'h000, 14'h0000);
    vectors++; if (sSeq !== 1'b0) begin miscompares++; $display("[TB] FAIL seq_pulse_width: got %0b expected 0", sSeq); end
    #2;
    vectors++; if (seqCount - s0 !== 1) begin miscompares++; $display("[TB] FAIL seq_count: got %0d expected 1", seqCount - s0); end
    vectors++; if (fvCount - f0 !== 0) begin miscompares++; $display("[TB] FAIL seq_no_frame: got %0d expected 0", fvCount - f0); end
    for (int a = 0; a < 12; a++) begin
      rd_addr = 4'(a);
      #1;
      vectors++;
      if (rd_char !== lastExp.codes[a]) begin miscompares++; $display("[TB] FAIL seq_keep[%0d]: got %0d expected %0d", a, rd_char, lastExp.codes[a]); end
    end
    f0 = fvCount;
    sendFrame(fb);
    idle(4);
    #2;
    vectors++; if (fvCount - f0 !== 1) begin miscompares++; $display("[TB] FAIL seq_relock: got %0d expected 1", fvCount - f0); end
    // An early digit 0 while capturing is an error, not the start of a new scan.
    s0 = seqCount; f0 = fvCount;
    for (int k = 0; k < 4; k++) applyStimulus(12'b1 << k, GLYPHS[1 + k]);
    for (int k = 0; k < 12; k++) applyStimulus(12'b1 << k, GLYPHS[10 + k]);
    idle(4);
    #2;
    vectors++; if (seqCount - s0 !== 1) begin miscompares++; $display("[TB] FAIL early0_seq: got %0d expected 1", seqCount - s0); end
    vectors++; if (fvCount - f0 !== 0) begin miscompares++; $display("[TB] FAIL early0_no_frame: got %0d expected 0", fvCount - f0); end
  endtask

  task automatic test_onehot();
    int s0, o0, f0;
    #2; s0 = seqCount; o0 = ohCount; f0 = fvCount;
    applyStimulus(12'h003, GLYPHS[1]);
    idle(2);
    vectors++; if (sOh !== 1'b1) begin miscompares++; $display("[TB] FAIL oh_hunt: got %0b expected 1", sOh); end
    for (int k = 0; k < 5; k++) applyStimulus(12'b1 << k, GLYPHS[2 + k]);
    applyStimulus(12'h003, GLYPHS[2]);
    applyStimulus(12'h000, 14'h0000);
    vectors++; if (sLocked !== 1'b1) begin miscompares++; $display("[TB] FAIL oh_prelock: got %0b expected 1", sLocked); end
    applyStimulus(12'h000, 14'h0000);
    vectors++; if (sOh !== 1'b1) begin miscompares++; $display("[TB] FAIL oh_pulse: got %0b expected 1", sOh); end
    vectors++; if (sSeq !== 1'b0) begin miscompares++; $display("[TB] FAIL oh_no_seq: got %0b expected 0", sSeq); end
    vectors++; if (sLocked !== 1'b0) begin miscompares++; $display("[TB] FAIL oh_unlock: got %0b expected 0", sLocked); end
    for (int k = 6; k < 12; k++) applyStimulus(12'b1 << k, GLYPHS[k]);
    idle(4);
    #2;
    vectors++; if (ohCount - o0 !== 2) begin miscompares++; $display("[TB] FAIL oh_count: got %0d expected 2", ohCount - o0); end
    vectors++; if (seqCount - s0 !== 0) begin miscompares++; $display("[TB] FAIL oh_seq_count: got %0d expected 0", seqCount - s0); end
    vectors++; if (fvCount - f0 !== 0) begin miscompares++; $display("[TB] FAIL oh_no_frame: got %0d expected 0", fvCount - f0); end
  endtask

  task automatic test_unknown();
    int f0;
    int fu [12] = '{8, 15, 15, 4, 0, 28, 63, 33, 19, 12, 11, 37};
    int fc [12] = '{3, 12, 5, 1, 14, 27, 0, 20, 9, 22, 25, 2};
    #2; f0 = fvCount;
    sendFrame(fu);
    sendFrame(fc);
    idle(4);
    #2;
    vectors++; if (fvCount - f0 !== 2) begin miscompares++; $display("[TB] FAIL unk_frames: got %0d expected 2", fvCount - f0); end
    vectors++; if (frame_unk !== 1'b0) begin miscompares++; $display("[TB] FAIL unk_cleared: got %0b expected 0", frame_unk); end
  endtask

  task automatic test_reset_midframe();
    int f0;
    int fr [12] = '{23, 9, 18, 5, 0, 1, 2, 3, 4, 5, 6, 7};
    for (int k = 0; k < 8; k++) applyStimulus(12'b1 << k, GLYPHS[20 + k]);
    #7;
    rst = 1'b1;
    #1;
    vectors++; if (frame_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL rstmid_cnt: got %0d expected 0", frame_cnt); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_locked: got %0b expected 0", locked); end
    vectors++; if ({frame_valid, frame_unk, seq_err, onehot_err} !== 4'b0) begin miscompares++; $display("[TB] FAIL rstmid_flags: got %b expected 0000", {frame_valid, frame_unk, seq_err, onehot_err}); end
    for (int a = 0; a < 12; a++) begin
      rd_addr = 4'(a);
      #1;
      vectors++;
      if (rd_char !== 6'd0) begin miscompares++; $display("[TB] FAIL rstmid_rd[%0d]: got %0d expected 0", a, rd_char); end
    end
    modelCnt = 8'd0;
    @(posedge clk);
    #3 rst = 1'b0;
    f0 = fvCount;
    idle(1);
    sendFrame(fr);
    idle(4);
    #2;
    vectors++; if (fvCount - f0 !== 1) begin miscompares++; $display("[TB] FAIL rstmid_recover: got %0d expected 1", fvCount - f0); end
  endtask

  task automatic test_continuous();
    int s0, o0, badGaps;
    int fr [12];
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelCnt = 8'd0;
    fvCycles.delete();
    s0 = seqCount; o0 = ohCount;
    for (int f = 0; f < 300; f++) begin
      for (int k = 0; k < 12; k++) fr[k] = int'($urandom_range(0, 37));
      sendFrame(fr);
      trackLock = 1'b1;
    end
    idle(2);
    trackLock = 1'b0;
    #2;
    vectors++; if (sCnt !== 8'd44) begin miscompares++; $display("[TB] FAIL cont_cnt: got %0d expected 44", sCnt); end
    vectors++; if (lockDrops !== 0) begin miscompares++; $display("[TB] FAIL cont_locked: got %0d drops expected 0", lockDrops); end
    vectors++; if (seqCount - s0 !== 0) begin miscompares++; $display("[TB] FAIL cont_seq: got %0d expected 0", seqCount - s0); end
    vectors++; if (ohCount - o0 !== 0) begin miscompares++; $display("[TB] FAIL cont_oh: got %0d expected 0", ohCount - o0); end
    vectors++; if (fvCycles.size() !== 300) begin miscompares++; $display("[TB] FAIL cont_frames: got %0d expected 300", fvCycles.size()); end
    badGaps = 0;
    for (int i = 1; i < fvCycles.size(); i++)
      if (fvCycles[i] - fvCycles[i-1] != 12) badGaps++;
    vectors++; if (badGaps !== 0) begin miscompares++; $display("[TB] FAIL cont_spacing: got %0d irregular gaps expected 0", badGaps); end
    idle(4);
  endtask

  initial begin
    lastExp = '0;
    test_reset();
    test_nominal();
    test_seq_error();
    test_onehot();
    test_unknown();
    test_reset_midframe();
    test_continuous();
    vectors++;
    if (expQ.size() !== 0) begin miscompares++; $display("[TB] FAIL missing_frames: got %0d pending expected 0", expQ.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
